rr_arbiter8: RTL and testbench
==============================

# rr_arbiter8

Round-robin arbiter that shares one resource among eight requesters. It issues a one-hot grant through an internal 3-to-8 decode of the winning index. Grants are registered and held until the owner releases or a hold-time limit expires. Ownership hands off back-to-back with no idle cycle. The block sits in front of any shared datapath unit whose select lines are driven one-hot from a 3-bit index.

## Interface
- `MAX_HOLD`, default 16: max consecutive grant cycles per owner, range 1..255; 0 disables timeout.
- `clk`  in  1  rising-edge clock, the only clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `req`  in  8  request vector; bit i is held high by requester i while it wants the resource.
- `done`  in  1  one-cycle release pulse from the current owner; ignored when no grant is active.
- `gnt`  out  8  one-hot grant; all zeros when idle.
- `gnt_idx`  out  3  index of the current owner; holds its last value when idle.
- `gnt_vld`  out  1  a grant is active.
- `timeout`  out  1  one-cycle pulse when a grant is revoked by `MAX_HOLD`.

## Operation
- **States:**
  - IDLE: no owner.
  - GRANT: `gnt_vld`=1.
- **Priority pointer `ptr` (3 b):**
  - Search order is `ptr`, `ptr`+1, … mod 8. The first set `req` bit wins.
  - After each grant, `ptr` = winner+1 mod 8 (wraps 7→0).
- **IDLE:**
  - `req`≠0 → load winner into `gnt_idx`, clear `hold_cnt`, go to GRANT.
  - `req`=0 → stay in IDLE.
- **GRANT termination events** (evaluated each cycle):
  - (a) `req[gnt_idx]`=0.
  - (b) `done`=1.
  - (c) `MAX_HOLD`≠0 and `hold_cnt`=`MAX_HOLD`−1.
- **No termination event:** `hold_cnt`++.
- **On termination:**
  - Search from `gnt_idx`+1 over all 8 bits, so the outgoing owner has lowest priority.
  - Winner found → grant it directly: stay in GRANT, reset `hold_cnt`.
  - No winner → go to IDLE.
- **`timeout`:** asserted for one cycle when termination is caused only by (c).
  - If (a) or (b) occurs in the same cycle, that is a normal release.
- **Sole requester timing out:** if it is still requesting, it is re-granted (it is the only winner). `timeout` still pulses.
- **`gnt` encoding:** decode of `gnt_idx` enabled by `gnt_vld`.
  - Never more than one bit set.
  - All zeros when `gnt_vld`=0.
- **`hold_cnt`:** 8 bits, never exceeds `MAX_HOLD`−1.

## Timing
- **Reset** (`rst_n`=0 sampled at an edge):
  - Outputs: `gnt`=0, `gnt_idx`=0, `gnt_vld`=0, `timeout`=0.
  - Internal: `ptr`=0, `hold_cnt`=0, state IDLE.
  - Reset mid-grant drops the grant on that same edge.
- **Grant latency:** `req` sampled at edge k → `gnt` visible after edge k.
- **Release latency:** release sampled at edge k → the new owner (or 0) is visible after edge k. There is no dead cycle between owners.
- **Hold limit:** the maximum continuous grant to one owner while others are waiting is `MAX_HOLD` cycles.
- **Combined events:** `done` together with `req[gnt_idx]` still high counts as a single release. The requester re-competes at lowest priority.
- **Glitch-free outputs:** all outputs come from flops or from a decode of flops. `req`/`done` do not reach the outputs combinationally.

## Structure
- **Shared package `arb_pkg`:**
  - `N_REQ`=8, `IDX_W`=3.
  - State enum {IDLE, GRANT}.
- **Sub-module `dec3to8_en`:** 3-to-8 decoder with enable. Inputs `gnt_idx`, `gnt_vld`; output `gnt`.
- **Priority search:** a function (rotate, find first set, un-rotate), used for both IDLE and handoff searches.

## Test plan
- **Reset and basic grant:** reset, then `req`=8'h00 → `gnt`=0, `gnt_vld`=0. Then `req`=8'h01 → `gnt`=8'h01, `gnt_idx`=0 one edge later. Then `req`=0 → `gnt`=0 next edge.
- **Rotation:** `req`=8'hFF held, `done` pulsed every 3rd cycle → `gnt_idx` goes 0,1,2,…,7,0, with no gap cycle between owners.
- **Timeout:** `MAX_HOLD`=4, `req`=8'h06 held, no `done` → idx1 granted for exactly 4 cycles with `timeout` pulsing, then idx2 for 4 cycles, then idx1.
- **Priority skip:** start with `ptr`=6 (after a grant to 5), `req`=8'h21 → idx0 wins over idx5.
- **Sole requester and combined events:**
  - Sole requester `req`=8'h80 with `MAX_HOLD`=2 → re-granted continuously, `timeout` every 2 cycles, `gnt` never drops.
  - `done` with `req` high and `MAX_HOLD` reached on the same cycle → no `timeout` pulse.
- **Reset mid-grant:** `rst_n`=0 while `gnt`=8'h10 → all outputs zero after that edge. After release of reset with `req`=8'h18, idx3 is granted (`ptr`=0).

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and the rotating priority search
// for the eight-way round-robin arbiter.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    // Returns {found, index}: the first set bit at or after start, mod N_REQ.
    function automatic logic [IDX_W:0] pick(
        input logic [N_REQ-1:0] req,
        input logic [IDX_W-1:0] start
    );
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   rot;
        logic [IDX_W-1:0]   off;
        logic               found;
        dbl   = {req, req};
        rot   = dbl[start +: N_REQ];
        off   = '0;
        found = 1'b0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off   = IDX_W'(j);
                found = 1'b1;
            end
        end
        return {found, start + off};
    endfunction

endpackage

// File: rtl/dec3to8_en.sv
// 3-to-8 one-hot decoder with enable;
// produces all zeros when disabled.
module dec3to8_en
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0] gnt_idx,
    input  logic             gnt_vld,
    output logic [N_REQ-1:0] gnt
);

    always_comb begin
        gnt = '0;
        if (gnt_vld) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered grant,
// back-to-back handoff and optional hold-time limit.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic             timeout
);

    localparam bit         HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [7:0]       hold_cnt;

    logic             ev_rel;
    logic             ev_done;
    logic             ev_lim;
    logic             term;
    logic [IDX_W-1:0] start;
    logic             found;
    logic [IDX_W-1:0] win;

    always_comb begin
        ev_rel  = !req[gnt_idx];
        ev_done = done;
        ev_lim  = HOLD_EN && (hold_cnt == HOLD_LAST);
        term    = (state == GRANT) && (ev_rel || ev_done || ev_lim);
        // The outgoing owner is searched last on handoff.
        start   = (state == GRANT) ? gnt_idx + 3'd1 : ptr;
        {found, win} = pick(req, start);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            gnt_idx  <= '0;
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        state    <= GRANT;
                        gnt_idx  <= win;
                        ptr      <= win + 3'd1;
                        hold_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (term) begin
                        timeout  <= ev_lim && !ev_rel && !ev_done;
                        hold_cnt <= '0;
                        if (found) begin
                            gnt_idx <= win;
                            ptr     <= win + 3'd1;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (HOLD_EN) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign gnt_vld = (state == GRANT);

    dec3to8_en u_dec (
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .gnt     (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed vector table plus hand sequences
// for the round-robin arbiter.
module tb_rr_arbiter8;

    logic       clk;
    logic       rst_n, rst2_n;
    logic [7:0] req, req2;
    logic       done, done2;
    logic [7:0] gnt, gnt2;
    logic [2:0] gnt_idx, gnt_idx2;
    logic       gnt_vld, gnt_vld2;
    logic       timeout, timeout2;

    int n_cmp = 0;
    int n_err = 0;

    rr_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    rr_arbiter8 #(.MAX_HOLD(2)) dut2 (
        .clk     (clk),
        .rst_n   (rst2_n),
        .req     (req2),
        .done    (done2),
        .gnt     (gnt2),
        .gnt_idx (gnt_idx2),
        .gnt_vld (gnt_vld2),
        .timeout (timeout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [7:0] req;
        logic       done;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       vld;
        logic       to;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic [7:0] rq,
                       input logic d, input logic [7:0] g,
                       input logic [2:0] i, input logic v,
                       input logic t);
        vec_t e;
        e.rst_n = r;
        e.req   = rq;
        e.done  = d;
        e.gnt   = g;
        e.idx   = i;
        e.vld   = v;
        e.to    = t;
        vq.push_back(e);
    endtask

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step2(input logic r, input logic [7:0] rq,
                         input logic d);
        @(negedge clk);
        rst2_n = r;
        req2   = rq;
        done2  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] ei;
        logic [7:0] eg;
        rst_n  = 1'b0;
        req    = '0;
        done   = 1'b0;
        rst2_n = 1'b0;
        req2   = '0;
        done2  = 1'b0;

        // reset and basic grant
        add(0, 8'h00, 0, 8'h00, 0, 0, 0);
        add(1, 8'h00, 0, 8'h00, 0, 0, 0);
        add(1, 8'h01, 0, 8'h01, 0, 1, 0);
        add(1, 8'h00, 0, 8'h00, 0, 0, 0);
        // rotation, done every third cycle
        add(0, 8'h00, 0, 8'h00, 0, 0, 0);
        add(1, 8'hFF, 0, 8'h01, 0, 1, 0);
        for (int c = 0; c < 25; c++) begin
            ei = 3'(((c + 1) / 3) % 8);
            eg = 8'h01 << ei;
            add(1, 8'hFF, (c % 3 == 2), eg, ei, 1, 0);
        end
        // hold limit of 4 with two requesters
        add(0, 8'h00, 0, 8'h00, 0, 0, 0);
        for (int k = 0; k < 12; k++) begin
            ei = ((k / 4) % 2 == 0) ? 3'd1 : 3'd2;
            eg = 8'h01 << ei;
            add(1, 8'h06, 0, eg, ei, 1, (k >= 4) && (k % 4 == 0));
        end
        // priority skip from ptr=6, combined done, idle index hold
        add(0, 8'h00, 0, 8'h00, 0, 0, 0);
        add(1, 8'h20, 0, 8'h20, 5, 1, 0);
        add(1, 8'h00, 0, 8'h00, 5, 0, 0);
        add(1, 8'h21, 0, 8'h01, 0, 1, 0);
        add(1, 8'h21, 1, 8'h20, 5, 1, 0);
        add(1, 8'h00, 0, 8'h00, 5, 0, 0);
        // reset mid-grant
        add(1, 8'h10, 0, 8'h10, 4, 1, 0);
        add(0, 8'h18, 0, 8'h00, 0, 0, 0);
        add(1, 8'h18, 0, 8'h08, 3, 1, 0);

        foreach (vq[n]) begin
            @(negedge clk);
            rst_n = vq[n].rst_n;
            req   = vq[n].req;
            done  = vq[n].done;
            @(posedge clk);
            #1;
            check($sformatf("v%0d.gnt", n), gnt, vq[n].gnt);
            check($sformatf("v%0d.idx", n), 8'(gnt_idx), 8'(vq[n].idx));
            check($sformatf("v%0d.vld", n), 8'(gnt_vld), 8'(vq[n].vld));
            check($sformatf("v%0d.to", n), 8'(timeout), 8'(vq[n].to));
        end

        // sole requester with hold limit 2
        step2(0, 8'h00, 0);
        check("s.rst.gnt", gnt2, 8'h00);
        check("s.rst.vld", 8'(gnt_vld2), 8'h00);
        for (int n = 0; n < 8; n++) begin
            step2(1, 8'h80, 0);
            check($sformatf("s%0d.gnt", n), gnt2, 8'h80);
            check($sformatf("s%0d.idx", n), 8'(gnt_idx2), 8'h07);
            check($sformatf("s%0d.to", n), 8'(timeout2),
                  8'((n > 0) && (n % 2 == 0)));
        end
        // done on the limit cycle is a plain release
        step2(1, 8'h80, 1);
        check("c.gnt", gnt2, 8'h80);
        check("c.to", 8'(timeout2), 8'h00);
        step2(1, 8'h80, 0);
        check("c1.to", 8'(timeout2), 8'h00);
        step2(1, 8'h80, 0);
        check("c2.to", 8'(timeout2), 8'h01);
        check("c2.gnt", gnt2, 8'h80);
        step2(1, 8'h00, 0);
        check("e.gnt", gnt2, 8'h00);
        check("e.vld", 8'(gnt_vld2), 8'h00);
        check("e.idx", 8'(gnt_idx2), 8'h07);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
